// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package pipe_ctrl_pkg;

    // Mul/div sequencer states
    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } md_state_e;

    // Per-stage control strobes, MSB first in the order the pipeline is drawn
    typedef struct packed {
        logic pc_stop;
        logic if_id_stop;
        logic if_id_flush;
        logic id_ex_stop;
        logic id_ex_flush;
        logic ex_mem_stop;
        logic ex_mem_flush;
        logic mem_wb_flush;
        logic muldiv_done;
    } ctrl_t;

    // x0 is hardwired to zero, so a load targeting it can never create a hazard
    localparam int ZERO_REG = 0;

endpackage

// File: rtl/muldiv_timer.sv
// Tracks a fixed-latency mul/div in EX: stalls the front end until the result is ready.
// Latency: done_o asserts MULDIV_LAT cycles after the trigger cycle (later if a memory wait holds it).
// Backpressure: counter keeps running under mem_stall_i; completion and new triggers wait for it to clear.
//
// Ports: clk/rst (sync, active-high), ex_muldiv_i (EX holds a mul/div),
//        mem_stall_i (MEM is waiting on data memory), md_stall_o (hold front end),
//        done_o (result valid, EX advances this cycle).
module muldiv_timer
    import pipe_ctrl_pkg::*;
#(
    parameter int MULDIV_LAT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic ex_muldiv_i,
    input  logic mem_stall_i,
    output logic md_stall_o,
    output logic done_o
);

    // Trigger cycle counts as the first stall cycle, so the counter starts one short
    localparam logic [3:0] CNT_LOAD = 4'(MULDIV_LAT - 1);

    md_state_e  state_q, state_d;
    logic [3:0] cnt_q, cnt_d;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        md_stall_o = 1'b0;
        done_o     = 1'b0;
        case (state_q)
            IDLE: begin
                md_stall_o = ex_muldiv_i;
                // A mul/div stuck behind a memory wait does not start until EX can own the unit
                if (ex_muldiv_i && !mem_stall_i) begin
                    state_d = BUSY;
                    cnt_d   = CNT_LOAD;
                end
            end
            BUSY: begin
                if (cnt_q != 4'd0) begin
                    md_stall_o = 1'b1;
                    cnt_d      = cnt_q - 4'd1;
                end else if (!mem_stall_i) begin
                    done_o  = 1'b1;
                    state_d = IDLE;
                end
                // cnt==0 under a memory wait: park here, result held until the pipe moves
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush sequencer: resolves memory wait, mul/div, taken branch and load-use into per-stage strobes.
// Latency: combinational from registered state plus inputs; no added cycles.
// Backpressure: memory wait freezes everything up to EX_MEM; mul/div freezes up to ID_EX; branches deferred under stalls.
//
// Ports: clk/rst (sync, active-high); ID source regs + use flags; EX rd, load, taken-branch, mul/div flags;
//        MEM request/ready; outputs are stop (hold) / flush (bubble) strobes per pipeline register,
//        plus muldiv_done_o.
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_AW     = 5,
    parameter int MULDIV_LAT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] id_rs1_i,
    input  logic [REG_AW-1:0] id_rs2_i,
    input  logic              id_use_rs1_i,
    input  logic              id_use_rs2_i,
    input  logic [REG_AW-1:0] ex_rd_i,
    input  logic              ex_mem_read_i,
    input  logic              ex_branch_taken_i,
    input  logic              ex_muldiv_i,
    input  logic              mem_req_i,
    input  logic              mem_ready_i,
    output logic              pc_stop_o,
    output logic              if_id_stop_o,
    output logic              if_id_flush_o,
    output logic              id_ex_stop_o,
    output logic              id_ex_flush_o,
    output logic              ex_mem_stop_o,
    output logic              ex_mem_flush_o,
    output logic              mem_wb_flush_o,
    output logic              muldiv_done_o
);

    logic  mem_stall;
    logic  md_stall;
    logic  md_done;
    logic  load_use;
    logic  branch_eff;
    logic  rst_d_q, rst_d_d;
    logic  branch_pend_q, branch_pend_d;
    ctrl_t ctrl;

    muldiv_timer #(
        .MULDIV_LAT (MULDIV_LAT)
    ) u_muldiv_timer (
        .clk         (clk),
        .rst         (rst),
        .ex_muldiv_i (ex_muldiv_i),
        .mem_stall_i (mem_stall),
        .md_stall_o  (md_stall),
        .done_o      (md_done)
    );

    assign mem_stall = mem_req_i & ~mem_ready_i;

    assign load_use = ex_mem_read_i && (ex_rd_i != REG_AW'(ZERO_REG)) &&
                      ((id_use_rs1_i && (id_rs1_i == ex_rd_i)) ||
                       (id_use_rs2_i && (id_rs2_i == ex_rd_i)));

    // A branch seen while stalled is remembered so it still redirects once the pipe moves
    assign branch_eff = ex_branch_taken_i | branch_pend_q;

    always_comb begin
        rst_d_d       = rst;
        branch_pend_d = 1'b0;
        if (!rst && (mem_stall || md_stall)) begin
            branch_pend_d = branch_eff;
        end
    end

    always_comb begin
        ctrl = '0;
        if (mem_stall) begin
            ctrl.pc_stop      = 1'b1;
            ctrl.if_id_stop   = 1'b1;
            ctrl.id_ex_stop   = 1'b1;
            ctrl.ex_mem_stop  = 1'b1;
            ctrl.mem_wb_flush = 1'b1;
        end else if (md_stall) begin
            ctrl.pc_stop      = 1'b1;
            ctrl.if_id_stop   = 1'b1;
            ctrl.id_ex_stop   = 1'b1;
            ctrl.ex_mem_flush = 1'b1;
        end else if (branch_eff) begin
            // PC keeps running so the redirect target loads this cycle
            ctrl.if_id_flush  = 1'b1;
            ctrl.id_ex_flush  = 1'b1;
        end else if (load_use) begin
            ctrl.pc_stop      = 1'b1;
            ctrl.if_id_stop   = 1'b1;
            ctrl.id_ex_flush  = 1'b1;
        end
        ctrl.muldiv_done = md_done;
        // Discard whatever was fetched while reset was releasing, unless IF_ID is being held
        if (rst_d_q && !ctrl.if_id_stop) begin
            ctrl.if_id_flush = 1'b1;
        end
        if (rst) begin
            ctrl = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rst_d_q       <= 1'b1;
            branch_pend_q <= 1'b0;
        end else begin
            rst_d_q       <= rst_d_d;
            branch_pend_q <= branch_pend_d;
        end
    end

    assign pc_stop_o      = ctrl.pc_stop;
    assign if_id_stop_o   = ctrl.if_id_stop;
    assign if_id_flush_o  = ctrl.if_id_flush;
    assign id_ex_stop_o   = ctrl.id_ex_stop;
    assign id_ex_flush_o  = ctrl.id_ex_flush;
    assign ex_mem_stop_o  = ctrl.ex_mem_stop;
    assign ex_mem_flush_o = ctrl.ex_mem_flush;
    assign mem_wb_flush_o = ctrl.mem_wb_flush;
    assign muldiv_done_o  = ctrl.muldiv_done;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with MULDIV_LAT = 4.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
// Output vector order: pc_stop, if_id_stop, if_id_flush, id_ex_stop, id_ex_flush, ex_mem_stop, ex_mem_flush, mem_wb_flush, muldiv_done.
module tb_pipeline_hazard_ctrl;

    localparam int REG_AW = 5;

    localparam logic [8:0] E_NONE = 9'b0_0_0_0_0_0_0_0_0;
    localparam logic [8:0] E_MEM  = 9'b1_1_0_1_0_1_0_1_0;
    localparam logic [8:0] E_MD   = 9'b1_1_0_1_0_0_1_0_0;
    localparam logic [8:0] E_BR   = 9'b0_0_1_0_1_0_0_0_0;
    localparam logic [8:0] E_LU   = 9'b1_1_0_0_1_0_0_0_0;
    localparam logic [8:0] E_DONE = 9'b0_0_0_0_0_0_0_0_1;
    localparam logic [8:0] E_RSTF = 9'b0_0_1_0_0_0_0_0_0;

    logic              clk;
    logic              rst;
    logic [REG_AW-1:0] id_rs1_i, id_rs2_i, ex_rd_i;
    logic              id_use_rs1_i, id_use_rs2_i;
    logic              ex_mem_read_i, ex_branch_taken_i, ex_muldiv_i;
    logic              mem_req_i, mem_ready_i;
    logic              pc_stop_o, if_id_stop_o, if_id_flush_o, id_ex_stop_o, id_ex_flush_o;
    logic              ex_mem_stop_o, ex_mem_flush_o, mem_wb_flush_o, muldiv_done_o;

    int n_cmp  = 0;
    int n_fail = 0;

    pipeline_hazard_ctrl #(
        .REG_AW     (REG_AW),
        .MULDIV_LAT (4)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .id_rs1_i          (id_rs1_i),
        .id_rs2_i          (id_rs2_i),
        .id_use_rs1_i      (id_use_rs1_i),
        .id_use_rs2_i      (id_use_rs2_i),
        .ex_rd_i           (ex_rd_i),
        .ex_mem_read_i     (ex_mem_read_i),
        .ex_branch_taken_i (ex_branch_taken_i),
        .ex_muldiv_i       (ex_muldiv_i),
        .mem_req_i         (mem_req_i),
        .mem_ready_i       (mem_ready_i),
        .pc_stop_o         (pc_stop_o),
        .if_id_stop_o      (if_id_stop_o),
        .if_id_flush_o     (if_id_flush_o),
        .id_ex_stop_o      (id_ex_stop_o),
        .id_ex_flush_o     (id_ex_flush_o),
        .ex_mem_stop_o     (ex_mem_stop_o),
        .ex_mem_flush_o    (ex_mem_flush_o),
        .mem_wb_flush_o    (mem_wb_flush_o),
        .muldiv_done_o     (muldiv_done_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic clr_inputs();
        id_rs1_i          = '0;
        id_rs2_i          = '0;
        id_use_rs1_i      = 1'b0;
        id_use_rs2_i      = 1'b0;
        ex_rd_i           = '0;
        ex_mem_read_i     = 1'b0;
        ex_branch_taken_i = 1'b0;
        ex_muldiv_i       = 1'b0;
        mem_req_i         = 1'b0;
        mem_ready_i       = 1'b0;
    endtask

    task automatic set_load_use();
        ex_mem_read_i = 1'b1;
        ex_rd_i       = 5'd5;
        id_rs1_i      = 5'd3;
        id_use_rs1_i  = 1'b1;
        id_rs2_i      = 5'd5;
        id_use_rs2_i  = 1'b1;
    endtask

    // Sample this cycle's outputs on the falling edge, then move past the next rising edge
    task automatic chk(input string tag, input logic [8:0] exp);
        logic [8:0] obs;
        @(negedge clk);
        obs = {pc_stop_o, if_id_stop_o, if_id_flush_o, id_ex_stop_o, id_ex_flush_o,
               ex_mem_stop_o, ex_mem_flush_o, mem_wb_flush_o, muldiv_done_o};
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        clr_inputs();
        rst = 1'b1;

        // Reset: outputs forced low even with hazards present on the inputs
        chk("rst_c0", E_NONE);
        set_load_use();
        ex_muldiv_i = 1'b1;
        chk("rst_c1", E_NONE);
        clr_inputs();
        ex_branch_taken_i = 1'b1;
        mem_req_i         = 1'b1;
        chk("rst_c2", E_NONE);
        clr_inputs();
        rst = 1'b0;
        chk("post_rst_flush", E_RSTF);
        chk("post_rst_quiet", E_NONE);

        // Load-use
        set_load_use();
        chk("load_use_rs2", E_LU);
        ex_mem_read_i = 1'b0;
        chk("no_load_no_stall", E_NONE);
        ex_mem_read_i = 1'b1;
        ex_rd_i       = 5'd0;
        id_rs2_i      = 5'd0;
        chk("load_use_x0", E_NONE);
        ex_rd_i      = 5'd7;
        id_rs1_i     = 5'd7;
        id_use_rs1_i = 1'b0;
        id_rs2_i     = 5'd2;
        chk("rs1_match_unused", E_NONE);
        id_use_rs1_i = 1'b1;
        chk("load_use_rs1", E_LU);

        // Branch beats load-use
        set_load_use();
        ex_branch_taken_i = 1'b1;
        chk("branch_over_lu", E_BR);
        clr_inputs();
        chk("after_branch", E_NONE);

        // Mul/div: 4 stall cycles, done, then back-to-back retrigger
        ex_muldiv_i = 1'b1;
        for (int i = 0; i < 4; i++) chk($sformatf("md1_stall_%0d", i), E_MD);
        chk("md1_done", E_DONE);
        for (int i = 0; i < 4; i++) chk($sformatf("md2_stall_%0d", i), E_MD);
        chk("md2_done", E_DONE);
        ex_muldiv_i = 1'b0;
        chk("md_idle", E_NONE);

        // Memory wait overlapping mul/div: T..T+1 mul/div, T+2..T+6 freeze, done at T+7
        ex_muldiv_i = 1'b1;
        chk("mdm_t0", E_MD);
        chk("mdm_t1", E_MD);
        mem_req_i   = 1'b1;
        mem_ready_i = 1'b0;
        for (int i = 2; i <= 6; i++) chk($sformatf("mdm_mem_t%0d", i), E_MEM);
        mem_ready_i = 1'b1;
        chk("mdm_done_t7", E_DONE);
        clr_inputs();
        chk("mdm_idle", E_NONE);

        // Branch arriving under a memory wait is deferred, not dropped
        mem_req_i         = 1'b1;
        ex_branch_taken_i = 1'b1;
        chk("br_mem_0", E_MEM);
        chk("br_mem_1", E_MEM);
        clr_inputs();
        chk("br_deferred", E_BR);
        chk("br_cleared", E_NONE);

        // Mul/div blocked by memory wait in IDLE starts only once the wait clears
        ex_muldiv_i = 1'b1;
        mem_req_i   = 1'b1;
        chk("md_blk_mem", E_MEM);
        mem_req_i = 1'b0;
        for (int i = 0; i < 4; i++) chk($sformatf("md_blk_stall_%0d", i), E_MD);
        chk("md_blk_done", E_DONE);
        ex_muldiv_i = 1'b0;
        chk("md_blk_idle", E_NONE);

        // Reset in the middle of a mul/div: back to IDLE, no done pulse
        ex_muldiv_i = 1'b1;
        chk("mdr_t0", E_MD);
        chk("mdr_t1", E_MD);
        rst = 1'b1;
        chk("mdr_rst", E_NONE);
        rst         = 1'b0;
        ex_muldiv_i = 1'b0;
        chk("mdr_release", E_RSTF);
        for (int i = 0; i < 4; i++) chk($sformatf("mdr_quiet_%0d", i), E_NONE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipeline registers (IF_ID, ID_EX, EX_MEM, MEM_WB) and the PC register.
- Resolves four hazard sources into per-stage stop/flush strobes:
  - load-use data hazard;
  - taken branch/jump from EX;
  - fixed-latency mul/div occupying EX;
  - data-memory wait in MEM.
- Each pipeline register applies stop above flush, so this block never asserts stop and flush to the same register in the same cycle.

Parameters:
- REG_AW, 5, register-address width.
- MULDIV_LAT, 4, total stall cycles for a mul/div in EX. Legal range 2..15.

Ports:
- clk, in, 1, pipeline clock.
- rst, in, 1, synchronous active-high reset.
- id_rs1_i, in, REG_AW, rs1 of instruction in ID.
- id_rs2_i, in, REG_AW, rs2 of instruction in ID.
- id_use_rs1_i, in, 1, ID instruction reads rs1.
- id_use_rs2_i, in, 1, ID instruction reads rs2.
- ex_rd_i, in, REG_AW, rd of instruction in EX.
- ex_mem_read_i, in, 1, EX instruction is a load.
- ex_branch_taken_i, in, 1, EX resolved a taken branch/jump.
- ex_muldiv_i, in, 1, EX holds a mul/div.
- mem_req_i, in, 1, MEM-stage instruction accesses data memory.
- mem_ready_i, in, 1, data memory completes the access this cycle.
- pc_stop_o, out, 1, hold PC.
- if_id_stop_o, out, 1, hold IF_ID.
- if_id_flush_o, out, 1, bubble into IF_ID.
- id_ex_stop_o, out, 1, hold ID_EX.
- id_ex_flush_o, out, 1, bubble into ID_EX.
- ex_mem_stop_o, out, 1, hold EX_MEM.
- ex_mem_flush_o, out, 1, bubble into EX_MEM.
- mem_wb_flush_o, out, 1, bubble into MEM_WB.
- muldiv_done_o, out, 1, mul/div result valid; EX advances this cycle.

Behaviour:
- Clocking and reset:
  - One clock. Reset is synchronous and active-high; ports are clk and rst.
  - During rst, all outputs are 0, state = IDLE, cnt = 0, rst_d = 1.
- Post-reset: rst_d is rst delayed one cycle. In the first cycle after rst deasserts, if_id_flush_o = 1 to discard the stale fetch.
- Hazard terms (combinational):
  - mem_stall = mem_req_i & ~mem_ready_i.
  - md_stall = (state==IDLE & ex_muldiv_i) | (state==BUSY & cnt!=0).
  - load_use = ex_mem_read_i & ex_rd_i!=0 & ((id_use_rs1_i & id_rs1_i==ex_rd_i) | (id_use_rs2_i & id_rs2_i==ex_rd_i)).
- Priority, highest first (only the winning action drives outputs; all other outputs are 0):
  1. mem_stall: pc/if_id/id_ex/ex_mem stop = 1, mem_wb_flush = 1.
  2. md_stall: pc/if_id/id_ex stop = 1, ex_mem_flush = 1.
  3. ex_branch_taken_i: if_id_flush = 1, id_ex_flush = 1. PC is not stopped, so the branch target loads.
  4. load_use: pc/if_id stop = 1, id_ex_flush = 1. This gives a one-cycle bubble.
- rst_d flush: ORs into if_id_flush_o only when if_id_stop_o = 0.
- Branch under a stall: a branch in EX during a stall is deferred, not lost. It flushes in the first unstalled cycle.
- Mul/div FSM, states IDLE and BUSY, with a 4-bit down-counter cnt:
  - IDLE & ex_muldiv_i & ~mem_stall: load cnt = MULDIV_LAT-1, go to BUSY.
  - BUSY & cnt!=0: cnt decrements every cycle, including during mem_stall (the unit runs independently).
  - BUSY & cnt==0 & ~mem_stall: muldiv_done_o = 1, md_stall = 0, EX advances, go to IDLE.
  - BUSY & cnt==0 & mem_stall: stay in BUSY with cnt = 0 and muldiv_done_o = 0 until mem_stall clears.
  - Net effect: a mul/div causes exactly MULDIV_LAT stall cycles when no memory stall occurs. muldiv_done_o asserts in cycle T+MULDIV_LAT, where T is the trigger cycle.
- Back-to-back mul/div: the IDLE entered on the done cycle re-triggers on the next EX instruction the following cycle.
- Reset mid-operation: rst in BUSY returns to IDLE, cnt = 0, no done pulse.
- Outputs are combinational from the registered state plus inputs. There is no added latency.

Decomposition:
- Package pipe_ctrl_pkg holds:
  - the state enum (IDLE, BUSY);
  - the ctrl_t struct bundling the nine stop/flush/done bits;
  - the constant ZERO_REG = 0.
- Optional sub-module muldiv_timer, which contains the FSM plus counter and outputs md_stall and done. The priority mux stays in the top.

Test Plan:
- Reset release: rst high 3 cycles then low -> all outputs 0 during reset; if_id_flush_o = 1 for exactly the first cycle after release.
- Load-use: ex_mem_read_i=1, ex_rd_i=5, id_rs2_i=5, id_use_rs2_i=1 -> pc_stop=if_id_stop=id_ex_flush=1 for one cycle. Repeat with ex_rd_i=0 -> no stall.
- Branch plus load-use in the same cycle: ex_branch_taken_i=1 with a load-use match -> if_id_flush=id_ex_flush=1, pc_stop=0.
- Mul/div, MULDIV_LAT=4: ex_muldiv_i=1 at T -> stops and ex_mem_flush high T..T+3; muldiv_done_o=1 at T+4 with all stops 0; state IDLE at T+5.
- Memory wait overlapping mul/div: trigger at T, mem_req_i=1 & mem_ready_i=0 from T+2..T+6 -> full freeze with mem_wb_flush=1 over T+2..T+6; done delayed to T+7.
- Mid-BUSY reset: rst at T+2 of a mul/div -> next cycle state IDLE, no muldiv_done_o, all outputs 0.
